multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Main control FSM for the 13-bit multi-cycle processor.
- Sequences each instruction through fetch, decode, execute, memory and write-back.
- Drives the program counter's update enable and op-select (increment vs. 6-bit branch), the instruction-register load, register-file write, ALU op and data-memory strobes.
- Owns the memory wait/timeout handshake and the halt/fault status.

Parameters:
- OPW, 4, opcode width; opcode = instr[12:9]
- MEM_TIMEOUT, 15, max cycles to wait for i_MemReady before fault; legal range 1..255

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- i_Start  in  1  leave IDLE and begin fetching
- i_Instr  in  13  instruction word from instruction memory at the current PC
- i_Zero  in  1  ALU zero flag, sampled in EXEC
- i_MemReady  in  1  data-memory completion strobe
- o_PC  out  1  PC update enable (one-cycle pulse)
- o_PCop  out  1  0 = PC+1, 1 = load branch target
- o_Branch  out  6  branch target, = IR[5:0]
- o_IRwrite  out  1  load instruction register
- o_RegWrite  out  1  register-file write enable
- o_MemRead  out  1  data-memory read request
- o_MemWrite  out  1  data-memory write request
- o_ALUop  out  3  ALU function
- o_Halt  out  1  core halted
- o_Fault  out  1  memory timeout occurred (sticky until reset)
- o_State  out  3  current state encoding, for debug

Behaviour:
- Clock, reset and registered state:
  - Everything is clocked on the rising edge of clk.
  - reset is synchronous and active-low: reset==0 at an edge forces state=IDLE, IR=0, wait counter=0, o_Halt=0, o_Fault=0.
  - Reset overrides every other input, including in the middle of a memory wait.
- Outputs and state encoding:
  - All strobe outputs are Moore, decoded from state and IR; after reset every strobe is 0, o_ALUop=0, o_Branch=0.
  - Encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, FAULT=7.
- Per-state actions and transitions:
  - IDLE: no strobes; go to FETCH when i_Start=1.
  - FETCH: o_IRwrite=1, o_PC=1, o_PCop=0 (PC increments); IR<=i_Instr; next DECODE.
  - DECODE: no strobes; next state chosen by IR opcode:
    - 1111 HALT -> HALT
    - 1011 JMP and 1010 BEQZ -> EXEC
    - all others -> EXEC
  - EXEC, ALU ops 0000-0111: o_ALUop=opcode[2:0]; next WB.
  - EXEC, LOAD 1000 / STORE 1001: o_ALUop=000 (address add); next MEM, wait counter cleared.
  - EXEC, BEQZ 1010: if i_Zero=1 then o_PC=1, o_PCop=1; next FETCH either way.
  - EXEC, JMP 1011: o_PC=1, o_PCop=1 unconditionally; next FETCH.
  - EXEC, opcodes 1100-1110: NOP; next FETCH.
  - MEM: o_MemRead (LOAD) or o_MemWrite (STORE) held high until i_MemReady=1.
    - When ready: LOAD -> WB, STORE -> FETCH.
    - Each not-ready cycle increments the counter.
    - If the counter reaches MEM_TIMEOUT with ready still low: go to FAULT and drop the request.
  - WB: o_RegWrite=1; next FETCH.
  - HALT: o_Halt=1; remain until reset. i_Start is ignored.
  - FAULT: o_Fault=1, o_Halt=1; remain until reset.
- o_Branch always reflects IR[5:0].
  - The PC latches it only when o_PC=1 and o_PCop=1.
  - Branch targets therefore span 0..63; the upper PC bits load as zero.
- Latencies with zero memory wait:
  - ALU: 4 cycles
  - LOAD: 5 cycles
  - STORE: 4 cycles
  - BEQZ/JMP/NOP: 3 cycles
- PC and IR sequencing rules:
  - The PC increment happens in FETCH, so a branch in EXEC overwrites the incremented value. No double update is possible.
  - At most one o_PC pulse per state.
  - IR is written only in FETCH; it is stable during every other state.
- Boundary cases:
  - i_MemReady already high on MEM entry: completes in 1 cycle.
  - i_MemReady outside MEM: ignored.
  - i_Start held high continuously: has no effect after leaving IDLE.
  - Ready arriving on the same cycle the counter hits the limit: ready wins.

Decomposition:
- Shared package ctrl_pkg holds:
  - state encodings
  - opcode constants OP_LOAD, OP_STORE, OP_BEQZ, OP_JMP, OP_HALT
  - ALU op constants
- One natural sub-module: mem_wait_timer (counter, clear, increment, timeout compare), parameterised by MEM_TIMEOUT.

Test Plan:
- ALU fetch: reset low 2 cycles, then i_Start=1, i_Instr=13'b0010_000000000 (ALU op 010).
  - o_State goes 1,2,3,5,1.
  - o_PC pulses once, in FETCH.
  - o_ALUop=010 in EXEC.
  - o_RegWrite=1 only in WB.
- Branch taken/not-taken: BEQZ with IR[5:0]=6'd37.
  - i_Zero=1: EXEC gives o_PC=1, o_PCop=1, o_Branch=37.
  - i_Zero=0: no o_PC in EXEC.
  - Both cases return to FETCH after 3 cycles.
- LOAD with wait: i_MemReady held low 3 cycles in MEM.
  - o_MemRead stays high for 4 cycles.
  - Then WB with o_RegWrite=1.
  - Total 8 cycles.
- STORE timeout: MEM_TIMEOUT=4, i_MemReady never asserted.
  - FAULT (state 7) after 4 MEM cycles.
  - o_Fault=o_Halt=1; o_MemWrite drops.
  - Only reset clears it.
- HALT: opcode 1111 -> o_Halt=1 from the cycle after DECODE.
  - i_Start pulses are ignored.
  - reset=0 returns to IDLE with all outputs 0.
- Reset mid-MEM: reset=0 while o_MemRead=1.
  - Next edge: state=IDLE, o_MemRead=0, counter=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle processor control path:
// FSM states, opcode constants and ALU function codes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_e;

  localparam logic [3:0] OP_LOAD  = 4'b1000;
  localparam logic [3:0] OP_STORE = 4'b1001;
  localparam logic [3:0] OP_BEQZ  = 4'b1010;
  localparam logic [3:0] OP_JMP   = 4'b1011;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  // Address computation for LOAD/STORE reuses the ALU add function.
  localparam logic [2:0] ALU_ADD  = 3'b000;

  function automatic logic is_alu_op(input logic [3:0] op);
    return !op[3];
  endfunction

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Handshake between the control FSM and the memory wait timer.
interface mem_wait_if;
  logic clr;
  logic inc;
  logic last;

  modport ctrl  (output clr, output inc, input  last);
  modport timer (input  clr, input  inc, output last);
endinterface

// File: rtl/multicycle_ctrl_timer.sv
// Memory wait counter: cleared on MEM entry, counts not-ready cycles and
// flags the final permitted cycle so the FSM can fault on it.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  mem_wait_if.timer   tmr
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (tmr.clr)
      cnt_d = '0;
    else if (tmr.inc)
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  // Last cycle: this not-ready cycle brings the count up to MEM_TIMEOUT.
  assign tmr.last = (cnt_q == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the 13-bit multi-cycle processor: fetch, decode,
// execute, memory and write-back sequencing plus halt/fault status.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned OPW         = 4,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_Start,
  input  logic [12:0] i_Instr,
  input  logic        i_Zero,
  input  logic        i_MemReady,
  output logic        o_PC,
  output logic        o_PCop,
  output logic [5:0]  o_Branch,
  output logic        o_IRwrite,
  output logic        o_RegWrite,
  output logic        o_MemRead,
  output logic        o_MemWrite,
  output logic [2:0]  o_ALUop,
  output logic        o_Halt,
  output logic        o_Fault,
  output logic [2:0]  o_State
);

  state_e          state_q;
  logic [12:0]     ir_q;
  logic            halt_q;
  logic            fault_q;
  logic [OPW-1:0]  opcode;
  logic            take_branch;
  logic            unused_ir;

  mem_wait_if u_wait_if ();

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_tmr (
    .clk   (clk),
    .reset (reset),
    .tmr   (u_wait_if.timer)
  );

  assign opcode    = ir_q[12 -: OPW];
  assign unused_ir = ^ir_q[8:6];

  assign u_wait_if.clr = (state_q == S_EXEC) && is_mem_op(opcode);
  assign u_wait_if.inc = (state_q == S_MEM) && !i_MemReady;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      halt_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE:   if (i_Start) state_q <= S_FETCH;
        S_FETCH: begin
          ir_q    <= i_Instr;
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          if (opcode == OP_HALT) begin
            state_q <= S_HALT;
            halt_q  <= 1'b1;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_mem_op(opcode))
            state_q <= S_MEM;
          else if (is_alu_op(opcode))
            state_q <= S_WB;
          else
            state_q <= S_FETCH;
        end
        // Ready is tested before the timeout so a late ready still completes.
        S_MEM: begin
          if (i_MemReady)
            state_q <= (opcode == OP_LOAD) ? S_WB : S_FETCH;
          else if (u_wait_if.last) begin
            state_q <= S_FAULT;
            halt_q  <= 1'b1;
            fault_q <= 1'b1;
          end
        end
        S_WB:     state_q <= S_FETCH;
        default:  state_q <= state_q;
      endcase
    end
  end

  assign take_branch = (state_q == S_EXEC) &&
                       ((opcode == OP_JMP) || ((opcode == OP_BEQZ) && i_Zero));

  always_comb begin
    o_PC       = (state_q == S_FETCH) || take_branch;
    o_PCop     = take_branch;
    o_IRwrite  = (state_q == S_FETCH);
    o_RegWrite = (state_q == S_WB);
    o_MemRead  = (state_q == S_MEM) && (opcode == OP_LOAD);
    o_MemWrite = (state_q == S_MEM) && (opcode == OP_STORE);
    o_ALUop    = ALU_ADD;
    if ((state_q == S_EXEC) && is_alu_op(opcode))
      o_ALUop = opcode[2:0];
  end

  assign o_Branch = ir_q[5:0];
  assign o_Halt   = halt_q;
  assign o_Fault  = fault_q;
  assign o_State  = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected output vectors
// for each instruction class, memory wait/timeout, halt and reset cases.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_Start;
  logic [12:0] i_Instr;
  logic        i_Zero;
  logic        i_MemReady;
  logic        o_PC, o_PCop, o_IRwrite, o_RegWrite, o_MemRead, o_MemWrite;
  logic        o_Halt, o_Fault;
  logic [5:0]  o_Branch;
  logic [2:0]  o_ALUop, o_State;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // {state, PC, PCop, IRwrite, RegWrite, MemRead, MemWrite, ALUop, Halt, Fault}
  logic [13:0] obs;
  assign obs = {o_State, o_PC, o_PCop, o_IRwrite, o_RegWrite, o_MemRead,
                o_MemWrite, o_ALUop, o_Halt, o_Fault};

  localparam logic [13:0] E_IDLE  = {3'd0, 6'b000000, 3'd0, 2'b00};
  localparam logic [13:0] E_FETCH = {3'd1, 6'b101000, 3'd0, 2'b00};
  localparam logic [13:0] E_DEC   = {3'd2, 6'b000000, 3'd0, 2'b00};
  localparam logic [13:0] E_EXEC0 = {3'd3, 6'b000000, 3'd0, 2'b00};
  localparam logic [13:0] E_EXBR  = {3'd3, 6'b110000, 3'd0, 2'b00};
  localparam logic [13:0] E_MEMR  = {3'd4, 6'b000010, 3'd0, 2'b00};
  localparam logic [13:0] E_MEMW  = {3'd4, 6'b000001, 3'd0, 2'b00};
  localparam logic [13:0] E_WB    = {3'd5, 6'b000100, 3'd0, 2'b00};
  localparam logic [13:0] E_HALT  = {3'd6, 6'b000000, 3'd0, 2'b10};
  localparam logic [13:0] E_FAULT = {3'd7, 6'b000000, 3'd0, 2'b11};

  multicycle_ctrl #(.OPW(4), .MEM_TIMEOUT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_Start    (i_Start),
    .i_Instr    (i_Instr),
    .i_Zero     (i_Zero),
    .i_MemReady (i_MemReady),
    .o_PC       (o_PC),
    .o_PCop     (o_PCop),
    .o_Branch   (o_Branch),
    .o_IRwrite  (o_IRwrite),
    .o_RegWrite (o_RegWrite),
    .o_MemRead  (o_MemRead),
    .o_MemWrite (o_MemWrite),
    .o_ALUop    (o_ALUop),
    .o_Halt     (o_Halt),
    .o_Fault    (o_Fault),
    .o_State    (o_State)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, state=%0d", o_State);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b0; i_Start = 1'b0; i_Instr = '0; i_Zero = 1'b0; i_MemReady = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if (obs !== E_IDLE) begin
      n_fail++; $display("FAIL reset_outputs got=%b exp=%b", obs, E_IDLE);
    end
    n_checks++;
    if (o_Branch !== 6'd0) begin
      n_fail++; $display("FAIL reset_branch got=%0d exp=0", o_Branch);
    end
  endtask

  task automatic test_alu();
    logic [13:0] e [5];
    e = '{E_FETCH, E_DEC, {3'd3, 6'b000000, 3'b010, 2'b00}, E_WB, E_FETCH};
    do_reset();
    i_Start = 1'b1; i_Instr = 13'b0010_000000000;
    i_MemReady = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #3;
      n_checks++;
      if (obs !== e[k]) begin
        n_fail++; $display("FAIL alu cyc%0d got=%b exp=%b", k, obs, e[k]);
      end
    end
  endtask

  task automatic run_branch(input logic [3:0] op, input logic [5:0] tgt,
                            input logic zero, input logic taken);
    logic [13:0] e [4];
    e = '{E_FETCH, E_DEC, (taken ? E_EXBR : E_EXEC0), E_FETCH};
    do_reset();
    i_Start = 1'b1; i_Instr = {op, 3'b101, tgt}; i_Zero = zero;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #3;
      n_checks++;
      if (obs !== e[k]) begin
        n_fail++; $display("FAIL branch op=%b z=%0b cyc%0d got=%b exp=%b", op, zero, k, obs, e[k]);
      end
      if (k == 2) begin
        n_checks++;
        if (o_Branch !== tgt) begin
          n_fail++; $display("FAIL branch_target got=%0d exp=%0d", o_Branch, tgt);
        end
      end
    end
  endtask

  task automatic test_branch();
    run_branch(4'b1010, 6'd37, 1'b1, 1'b1);
    run_branch(4'b1010, 6'd37, 1'b0, 1'b0);
    run_branch(4'b1011, 6'd63, 1'b0, 1'b1);
    run_branch(4'b1100, 6'd12, 1'b1, 1'b0);
  endtask

  task automatic test_load_wait();
    logic [13:0] e [9];
    e = '{E_FETCH, E_DEC, E_EXEC0, E_MEMR, E_MEMR, E_MEMR, E_MEMR, E_WB, E_FETCH};
    do_reset();
    i_Start = 1'b1; i_Instr = {4'b1000, 9'h0AB};
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #2;
      // Ready only on the fourth MEM cycle, where the count is at its limit.
      i_MemReady = (k == 6);
      #1;
      n_checks++;
      if (obs !== e[k]) begin
        n_fail++; $display("FAIL load_wait cyc%0d got=%b exp=%b", k, obs, e[k]);
      end
    end
  endtask

  task automatic test_store_ready();
    logic [13:0] e [5];
    e = '{E_FETCH, E_DEC, E_EXEC0, E_MEMW, E_FETCH};
    do_reset();
    i_Start = 1'b1; i_Instr = {4'b1001, 9'h011}; i_MemReady = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #3;
      n_checks++;
      if (obs !== e[k]) begin
        n_fail++; $display("FAIL store_ready cyc%0d got=%b exp=%b", k, obs, e[k]);
      end
    end
  endtask

  task automatic test_store_timeout();
    logic [13:0] e [11];
    e = '{E_FETCH, E_DEC, E_EXEC0, E_MEMW, E_MEMW, E_MEMW, E_MEMW,
          E_FAULT, E_FAULT, E_FAULT, E_FAULT};
    do_reset();
    i_Start = 1'b1; i_Instr = {4'b1001, 9'h022};
    for (int k = 0; k < 11; k++) begin
      @(posedge clk); #2;
      if (k >= 7) begin
        i_Start    = k[0];
        i_MemReady = 1'b1;
      end
      #1;
      n_checks++;
      if (obs !== e[k]) begin
        n_fail++; $display("FAIL store_timeout cyc%0d got=%b exp=%b", k, obs, e[k]);
      end
    end
    reset = 1'b0;
    @(posedge clk); #3;
    n_checks++;
    if (obs !== E_IDLE) begin
      n_fail++; $display("FAIL fault_clear got=%b exp=%b", obs, E_IDLE);
    end
    reset = 1'b1;
  endtask

  task automatic test_halt();
    logic [13:0] e [7];
    e = '{E_FETCH, E_DEC, E_HALT, E_HALT, E_HALT, E_HALT, E_HALT};
    do_reset();
    i_Start = 1'b1; i_Instr = {4'b1111, 9'h1FF};
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #2;
      if (k >= 2) i_Start = ~k[0];
      #1;
      n_checks++;
      if (obs !== e[k]) begin
        n_fail++; $display("FAIL halt cyc%0d got=%b exp=%b", k, obs, e[k]);
      end
    end
    reset = 1'b0;
    @(posedge clk); #3;
    n_checks++;
    if ({obs, o_Branch} !== {E_IDLE, 6'd0}) begin
      n_fail++; $display("FAIL halt_clear got=%b/%0d exp=%b/0", obs, o_Branch, E_IDLE);
    end
    reset = 1'b1;
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    i_Start = 1'b1; i_Instr = {4'b1000, 9'h005};
    repeat (5) @(posedge clk);
    #3;
    n_checks++;
    if (obs !== E_MEMR || dut.u_tmr.cnt_q !== 8'd1) begin
      n_fail++; $display("FAIL mid_mem_pre got=%b cnt=%0d exp=%b cnt=1", obs, dut.u_tmr.cnt_q, E_MEMR);
    end
    reset = 1'b0;
    @(posedge clk); #3;
    n_checks++;
    if (obs !== E_IDLE || dut.u_tmr.cnt_q !== 8'd0) begin
      n_fail++; $display("FAIL mid_mem_reset got=%b cnt=%0d exp=%b cnt=0", obs, dut.u_tmr.cnt_q, E_IDLE);
    end
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_load_wait();
    test_store_ready();
    test_store_timeout();
    test_halt();
    test_reset_mid_mem();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
